// File: rtl/truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// truth_table_sweeper
//
// Drives all sixteen {a,b,c,d} combinations into a 4-input combinational block
// in ascending order. Each pattern is held for HOLD_CYCLES clocks. On the last
// clock of each hold, the block's F output is sampled and compared against
// EXPECTED[pattern]. The sweep reports a pass flag, a mismatch count and a
// per-pattern failure mask.
//
// Parameters
//   HOLD_CYCLES  clocks per pattern, 1..65535
//   EXPECTED     expected truth table; bit i is F for {a,b,c,d} == i
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sweep (honoured only while idle)
//   f          in   F output of the block under check
//   a,b,c,d    out  registered pattern bits, a is the MSB
//   busy       out  high while patterns are being driven
//   done       out  one-cycle pulse at the end of a sweep
//   pass       out  last sweep had zero mismatches
//   err_count  out  number of mismatching patterns, 0..16
//   fail_mask  out  bit i set when pattern i mismatched
// ----------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int unsigned HOLD_CYCLES = 50,
  parameter logic [15:0] EXPECTED    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [15:0] fail_mask
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q,   idx_d;
  logic [15:0] hold_q,  hold_d;
  logic [4:0]  err_q,   err_d;
  logic [15:0] mask_q,  mask_d;
  logic        pass_q,  pass_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = 4'd0;
          hold_d  = 16'd0;
          err_d   = 5'd0;
          mask_d  = 16'h0000;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        if (hold_q == HOLD_LAST) begin
          // The sampling edge is also the edge that applies the next pattern.
          hold_d = 16'd0;
          if (f != EXPECTED[idx_q]) begin
            mask_d[idx_q] = 1'b1;
            err_d         = err_q + 5'd1;
          end
          if (idx_q == 4'hF) begin
            // Pass must include the pattern-15 result, so use err_d here.
            state_d = S_DONE;
            idx_d   = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 5'd0);
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      hold_q  <= 16'd0;
      err_q   <= 5'd0;
      mask_q  <= 16'h0000;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The index register is forced to 0 outside RUN, so it drives the
  // pattern pins directly.
  assign {a, b, c, d} = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign fail_mask    = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Two sweeper instances: one with HOLD_CYCLES=4 and EXPECTED=16'hF888, whose
// F comes from a behavioural model selected by 'mode'; one with
// HOLD_CYCLES=1 and EXPECTED=16'hFFFF, with F tied high.
// ----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // H=4 instance
  logic        start4, f4;
  logic        a4, b4, c4, d4, busy4, done4, pass4;
  logic [4:0]  err4;
  logic [15:0] mask4;

  // H=1 instance
  logic        start1;
  logic        f1;
  logic        a1, b1, c1, d1, busy1, done1, pass1;
  logic [4:0]  err1;
  logic [15:0] mask1;

  // mode 0: F = (a&b)|(c&d); 1: F = 0; 2: as mode 0 but forced 1 at pattern 6
  logic [1:0] mode;

  assign f4 = (mode == 2'd1) ? 1'b0 :
              (((a4 & b4) | (c4 & d4)) | ((mode == 2'd2) && ({a4, b4, c4, d4} == 4'd6)));
  assign f1 = 1'b1;

  truth_table_sweeper #(.HOLD_CYCLES(4), .EXPECTED(16'hF888)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .f(f4),
    .a(a4), .b(b4), .c(c4), .d(d4),
    .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .fail_mask(mask4)
  );

  truth_table_sweeper #(.HOLD_CYCLES(1), .EXPECTED(16'hFFFF)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .f(f1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle4(input string tag);
    check({tag, " abcd"}, {28'd0, a4, b4, c4, d4}, 32'd0);
    check({tag, " busy"}, {31'd0, busy4}, 32'd0);
    check({tag, " done"}, {31'd0, done4}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        poke;   // pulse start during RUN and during DONE
    logic [4:0]  err;
    logic [15:0] mask;
    logic        pass;
  } vec_t;

  vec_t vecs[4];

  initial begin
    // Watchdog: the directed sequence is far shorter than this.
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{mode: 2'd0, poke: 1'b1, err: 5'd0, mask: 16'h0000, pass: 1'b1};
    vecs[1] = '{mode: 2'd1, poke: 1'b0, err: 5'd7, mask: 16'hF888, pass: 1'b0};
    vecs[2] = '{mode: 2'd0, poke: 1'b0, err: 5'd0, mask: 16'h0000, pass: 1'b1};
    vecs[3] = '{mode: 2'd2, poke: 1'b0, err: 5'd1, mask: 16'h0040, pass: 1'b0};

    rst_n  = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    mode   = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_idle4("reset");
    check("reset pass", {31'd0, pass4}, 32'd0);
    check("reset err", {27'd0, err4}, 32'd0);
    check("reset mask", {16'd0, mask4}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- table-driven sweeps on the H=4 instance ----
    for (int v = 0; v < 4; v++) begin
      mode = vecs[v].mode;
      if (v > 0) begin
        check($sformatf("v%0d held err", v), {27'd0, err4}, {27'd0, vecs[v-1].err});
        check($sformatf("v%0d held mask", v), {16'd0, mask4}, {16'd0, vecs[v-1].mask});
      end
      start4 = 1'b1;
      tick();  // edge k
      start4 = 1'b0;
      check($sformatf("v%0d accept busy", v), {31'd0, busy4}, 32'd1);
      check($sformatf("v%0d accept abcd", v), {28'd0, a4, b4, c4, d4}, 32'd0);
      check($sformatf("v%0d accept err", v), {27'd0, err4}, 32'd0);
      check($sformatf("v%0d accept mask", v), {16'd0, mask4}, 32'd0);
      check($sformatf("v%0d accept pass", v), {31'd0, pass4}, 32'd0);

      for (int n = 1; n <= 66; n++) begin
        start4 = vecs[v].poke && (n == 21 || n == 65);
        tick();  // edge k+n
        start4 = 1'b0;
        if (n < 64) begin
          check($sformatf("v%0d n%0d abcd", v, n), {28'd0, a4, b4, c4, d4}, n / 4);
          check($sformatf("v%0d n%0d busy", v, n), {30'd0, busy4, done4}, 32'd2);
        end else if (n == 64) begin
          check($sformatf("v%0d end busy/done", v), {30'd0, busy4, done4}, 32'd1);
          check($sformatf("v%0d end abcd", v), {28'd0, a4, b4, c4, d4}, 32'd0);
          check($sformatf("v%0d err", v), {27'd0, err4}, {27'd0, vecs[v].err});
          check($sformatf("v%0d mask", v), {16'd0, mask4}, {16'd0, vecs[v].mask});
          check($sformatf("v%0d pass", v), {31'd0, pass4}, {31'd0, vecs[v].pass});
        end else begin
          check_idle4($sformatf("v%0d post n%0d", v, n));
          check($sformatf("v%0d post err", v), {27'd0, err4}, {27'd0, vecs[v].err});
          check($sformatf("v%0d post pass", v), {31'd0, pass4}, {31'd0, vecs[v].pass});
        end
      end
    end

    // ---- minimum hold on the H=1 instance ----
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("h1 accept busy", {31'd0, busy1}, 32'd1);
    check("h1 accept abcd", {28'd0, a1, b1, c1, d1}, 32'd0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (n < 16) begin
        check($sformatf("h1 n%0d abcd", n), {28'd0, a1, b1, c1, d1}, n);
        check($sformatf("h1 n%0d busy/done", n), {30'd0, busy1, done1}, 32'd2);
      end else if (n == 16) begin
        check("h1 end busy/done", {30'd0, busy1, done1}, 32'd1);
        check("h1 pass", {31'd0, pass1}, 32'd1);
        check("h1 err", {27'd0, err1}, 32'd0);
        check("h1 mask", {16'd0, mask1}, 32'd0);
      end else begin
        check("h1 post busy/done", {30'd0, busy1, done1}, 32'd0);
      end
    end

    // ---- asynchronous reset mid-sweep (pattern 5, failing model) ----
    mode   = 2'd1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (21) tick();
    check("mid abcd", {28'd0, a4, b4, c4, d4}, 32'd5);
    check("mid err", {27'd0, err4}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_idle4("async rst");
    check("async rst err", {27'd0, err4}, 32'd0);
    check("async rst mask", {16'd0, mask4}, 32'd0);
    check("async rst pass", {31'd0, pass4}, 32'd0);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check_idle4($sformatf("post rst %0d", n));
      check($sformatf("post rst err %0d", n), {27'd0, err4}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
